seq_divider: RTL and testbench

- Sequential restoring divider. It is the inverse-operation companion to the team's shift-add multiplier.
- Takes an unsigned DW-bit dividend X and a VW-bit divisor Y and produces the quotient and remainder, one quotient bit per clock.
- Uses the same start/Done handshake as the multiplier, so the two can share the same control and bench infrastructure.

---
 rtl/seq_divider_if.sv | 23 ++
 rtl/seq_divider.sv | 94 +++++++++
 tb/tb_seq_divider.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/Done handshake bundle for the sequential divider
interface seq_divider_if #(
   parameter int DW = 10,
   parameter int VW = 5
);
   logic [DW-1:0] X;
   logic [VW-1:0] Y;
   logic          start;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          Done;
   logic          div_by_zero;

   modport master (
      output X, Y, start,
      input  quotient, remainder, Done, div_by_zero
   );

   modport slave (
      input  X, Y, start,
      output quotient, remainder, Done, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per clock
module seq_divider #(
   parameter int DW = 10,
   parameter int VW = 5
) (
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   d_q, d_d;      // dividend shifting out, quotient shifting in
   logic [VW:0]     r_q, r_d;      // partial remainder, one guard bit for the shift
   logic [VW-1:0]   dv_q, dv_d;    // divisor captured at start
   logic [CW-1:0]   cnt_q, cnt_d;  // quotient bits still to produce
   logic            dz_q, dz_d;
   logic [VW:0]     trial;
   logic            done;

   // State and datapath registers; reset aborts any division in progress
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         d_q     <= '0;
         r_q     <= '0;
         dv_q    <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         r_q     <= r_d;
         dv_q    <= dv_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
      end
   end

   // Next state: capture on start from IDLE/DONE, one restoring step per BUSY cycle
   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      r_d     = r_q;
      dv_d    = dv_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      trial   = {r_q[VW-1:0], d_q[DW-1]};
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               d_d   = bus.X;
               dv_d  = bus.Y;
               r_d   = '0;
               cnt_d = CW'(DW);
               if (bus.Y == '0) begin
                  // Division by zero finishes at once with a saturated quotient
                  state_d = DONE;
                  d_d     = '1;
                  dz_d    = 1'b1;
               end else begin
                  state_d = BUSY;
                  dz_d    = 1'b0;
               end
            end
         end
         BUSY: begin
            if (trial >= {1'b0, dv_q}) begin
               r_d = trial - {1'b0, dv_q};
               d_d = {d_q[DW-2:0], 1'b1};
            end else begin
               r_d = trial;
               d_d = {d_q[DW-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: results are presented only in DONE, zero otherwise
   always_comb begin
      done            = (state_q == DONE);
      bus.Done        = done;
      bus.quotient    = done ? d_q : '0;
      bus.remainder   = done ? r_q[VW-1:0] : '0;
      bus.div_by_zero = done & dz_q;
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider
module tb_seq_divider;
   localparam int DW = 10;
   localparam int VW = 5;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   seq_divider_if #(.DW(DW), .VW(VW)) bus ();

   seq_divider #(.DW(DW), .VW(VW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an operation is "in flight" for DW cycles, then holds X/Y and X%Y
   logic m_busy, m_done, m_dz;
   int   m_left, m_q, m_r;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_dz   <= 1'b0;
         m_left <= 0;
         m_q    <= 0;
         m_r    <= 0;
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
         end
      end else if (bus.start) begin
         if (bus.Y == 0) begin
            m_done <= 1'b1;
            m_dz   <= 1'b1;
            m_q    <= (1 << DW) - 1;
            m_r    <= 0;
         end else begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_left <= DW;
            m_q    <= int'(bus.X) / int'(bus.Y);
            m_r    <= int'(bus.X) % int'(bus.Y);
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         chk("model_done", int'(bus.Done), int'(m_done));
         if (m_done) begin
            chk("model_quotient", int'(bus.quotient), m_q);
            chk("model_remainder", int'(bus.remainder), m_r);
            chk("model_dbz", int'(bus.div_by_zero), int'(m_dz));
         end
      end
   end

   // Caller sits at a negedge; returns at the negedge just after the start edge
   task automatic start_op(input int x, input int y);
      bus.X     = DW'(x);
      bus.Y     = VW'(y);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Bounded wait for Done; lat counts edges after the start edge
   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (!bus.Done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_lit(input string name, input int x, input int y,
                          input int eq, input int er, input int edz, input int elat);
      int lat;
      start_op(x, y);
      wait_done(0, lat);
      chk({name, "_latency"}, lat, elat);
      chk({name, "_quotient"}, int'(bus.quotient), eq);
      chk({name, "_remainder"}, int'(bus.remainder), er);
      chk({name, "_dbz"}, int'(bus.div_by_zero), edz);
   endtask

   initial begin
      int lat, x, y, q, r;
      rst       = 1'b0;
      bus.X     = '0;
      bus.Y     = '0;
      bus.start = 1'b0;
      #2;
      chk("reset_done", int'(bus.Done), 0);
      chk("reset_quotient", int'(bus.quotient), 0);
      chk("reset_remainder", int'(bus.remainder), 0);
      chk("reset_dbz", int'(bus.div_by_zero), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Basic case, then results must hold while idle in DONE
      run_lit("x100_y7", 100, 7, 14, 2, 0, DW);
      repeat (20) @(negedge clk);
      chk("hold_done", int'(bus.Done), 1);
      chk("hold_quotient", int'(bus.quotient), 14);
      chk("hold_remainder", int'(bus.remainder), 2);

      run_lit("x1023_y31", 1023, 31, 33, 0, 0, DW);
      run_lit("x5_y9", 5, 9, 0, 5, 0, DW);
      run_lit("x31_y1", 31, 1, 31, 0, 0, DW);
      run_lit("x77_y0", 77, 0, 1023, 0, 1, 0);
      run_lit("x0_y5", 0, 5, 0, 0, 0, DW);

      // start held high and operands changed while busy must be ignored
      start_op(200, 13);
      bus.start = 1'b1;
      bus.X     = 10'd3;
      bus.Y     = 5'd0;
      @(negedge clk);
      bus.X     = 10'd1000;
      bus.Y     = 5'd2;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(3, lat);
      chk("busy_ign_latency", lat, DW);
      chk("busy_ign_quotient", int'(bus.quotient), 15);
      chk("busy_ign_remainder", int'(bus.remainder), 5);

      // Asynchronous reset mid-operation
      start_op(500, 3);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("async_rst_done", int'(bus.Done), 0);
      chk("async_rst_quotient", int'(bus.quotient), 0);
      chk("async_rst_remainder", int'(bus.remainder), 0);
      chk("async_rst_dbz", int'(bus.div_by_zero), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_lit("x500_y3", 500, 3, 166, 2, 0, DW);

      // Random sweep with back-to-back restarts from DONE
      for (int i = 0; i < 500; i++) begin
         x = int'($urandom_range(0, (1 << DW) - 1));
         y = int'($urandom_range(1, (1 << VW) - 1));
         start_op(x, y);
         wait_done(0, lat);
         q = int'(bus.quotient);
         r = int'(bus.remainder);
         chk("rand_latency", lat, DW);
         chk("rand_identity", q * y + r, x);
         chk("rand_rem_lt_div", int'(r < y), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
